// File: rtl/eth_hdr_parser.sv
// eth_hdr_parser: splits an AXI-Stream Ethernet frame into header fields and a registered payload stream
// Optional frame/early-termination counters when ETH_HDR_PARSER_STATS_EN is defined.
module eth_hdr_parser (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        m_eth_hdr_valid,
  input  logic        m_eth_hdr_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,
  output logic [7:0]  m_eth_axi_payload_tdata,
  output logic        m_eth_axi_payload_tvalid,
  input  logic        m_eth_axi_payload_tready,
  output logic        m_eth_axi_payload_tlast,
  output logic        m_eth_axi_payload_tuser,
  output logic        busy,
`ifdef ETH_HDR_PARSER_STATS_EN
  output logic [31:0] stat_frames,
  output logic [31:0] stat_early_term,
`endif
  output logic        err_hdr_early_termination
);
  typedef enum logic {HDR, PAYLOAD} state_t;
  state_t state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [111:0] hdr_q, hdr_d;
  logic         hdr_valid_q, hdr_valid_d;
  logic [7:0]   pl_data_q, pl_data_d;
  logic         pl_valid_q, pl_valid_d;
  logic         pl_last_q, pl_last_d;
  logic         pl_user_q, pl_user_d;
  logic         err_q, err_d;
  logic         hdr_xfer, pl_xfer, hdr_hs;
  always_comb begin
    s_axis_tready = !reset && (state_q == HDR ? !hdr_valid_q : (!pl_valid_q || m_eth_axi_payload_tready));
    hdr_xfer = s_axis_tvalid && s_axis_tready && state_q == HDR;
    pl_xfer = s_axis_tvalid && s_axis_tready && state_q == PAYLOAD;
    hdr_hs = hdr_valid_q && m_eth_hdr_ready;
    state_d = state_q;
    cnt_d = cnt_q;
    hdr_d = hdr_q;
    pl_data_d = pl_data_q;
    pl_last_d = pl_last_q;
    pl_user_d = pl_user_q;
    pl_valid_d = pl_valid_q && !m_eth_axi_payload_tready;
    err_d = hdr_xfer && s_axis_tlast;
    hdr_valid_d = (hdr_xfer && cnt_q == 4'd13 && !s_axis_tlast) || (hdr_valid_q && !hdr_hs);
    // Header bytes shift in MSB-first, so the 112-bit register ends up dest|src|type
    if (hdr_xfer) begin
      hdr_d = {hdr_q[103:0], s_axis_tdata};
      cnt_d = s_axis_tlast ? 4'd0 : (cnt_q == 4'd13 ? 4'd13 : cnt_q + 4'd1);
      state_d = (cnt_q == 4'd13 && !s_axis_tlast) ? PAYLOAD : HDR;
    end
    if (pl_xfer) begin
      pl_data_d = s_axis_tdata;
      pl_valid_d = 1'b1;
      pl_last_d = s_axis_tlast;
      pl_user_d = s_axis_tlast && s_axis_tuser;
      state_d = s_axis_tlast ? HDR : PAYLOAD;
      cnt_d = s_axis_tlast ? 4'd0 : cnt_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HDR;
      cnt_q <= '0;
      hdr_q <= '0;
      hdr_valid_q <= 1'b0;
      pl_data_q <= '0;
      pl_valid_q <= 1'b0;
      pl_last_q <= 1'b0;
      pl_user_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hdr_q <= hdr_d;
      hdr_valid_q <= hdr_valid_d;
      pl_data_q <= pl_data_d;
      pl_valid_q <= pl_valid_d;
      pl_last_q <= pl_last_d;
      pl_user_q <= pl_user_d;
      err_q <= err_d;
    end
  end
  assign m_eth_hdr_valid = hdr_valid_q;
  assign m_eth_dest_mac = hdr_q[111:64];
  assign m_eth_src_mac = hdr_q[63:16];
  assign m_eth_type = hdr_q[15:0];
  assign m_eth_axi_payload_tdata = pl_data_q;
  assign m_eth_axi_payload_tvalid = pl_valid_q;
  assign m_eth_axi_payload_tlast = pl_last_q;
  assign m_eth_axi_payload_tuser = pl_user_q;
  assign busy = state_q == PAYLOAD || cnt_q != 4'd0;
  assign err_hdr_early_termination = err_q;
`ifdef ETH_HDR_PARSER_STATS_EN
  logic [31:0] frames_q, frames_d, early_q, early_d;
  always_comb begin
    frames_d = frames_q + 32'(hdr_hs);
    early_d = early_q + 32'(err_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_q <= '0;
      early_q <= '0;
    end else begin
      frames_q <= frames_d;
      early_q <= early_d;
    end
  end
  assign stat_frames = frames_q;
  assign stat_early_term = early_q;
`endif
endmodule

// File: tb/tb_eth_hdr_parser.sv
// tb_eth_hdr_parser: directed frames checked against a queue-based frame model
module tb_eth_hdr_parser;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
  logic hdr_valid, hdr_ready = 1'b1;
  logic [47:0] dest, src;
  logic [15:0] etype;
  logic [7:0] pl_data;
  logic pl_valid, pl_ready = 1'b1, pl_last, pl_user, busy, err;
  logic pl_toggle = 1'b0;
`ifdef ETH_HDR_PARSER_STATS_EN
  logic [31:0] stat_frames, stat_early_term;
`endif
  int n_cmp = 0, n_fail = 0;
  int drv_idx = -1, exp_err = 0, err_seen = 0, hdr_cnt = 0, pl_cnt = 0;
  logic err_prev = 1'b0;
  logic [111:0] hq[$];
  logic [9:0] pq[$];
  logic [111:0] last_hdr = '0;
  logic [9:0] last_pl = '0;

  eth_hdr_parser dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_eth_hdr_valid(hdr_valid), .m_eth_hdr_ready(hdr_ready),
    .m_eth_dest_mac(dest), .m_eth_src_mac(src), .m_eth_type(etype),
    .m_eth_axi_payload_tdata(pl_data), .m_eth_axi_payload_tvalid(pl_valid),
    .m_eth_axi_payload_tready(pl_ready), .m_eth_axi_payload_tlast(pl_last),
    .m_eth_axi_payload_tuser(pl_user), .busy(busy),
`ifdef ETH_HDR_PARSER_STATS_EN
    .stat_frames(stat_frames), .stat_early_term(stat_early_term),
`endif
    .err_hdr_early_termination(err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 pl_ready = pl_toggle ? !pl_ready : 1'b1;
  end

  task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pbyte(input int i, input int len);
    return 8'(i * 7 + len);
  endfunction

  always @(negedge clk) begin
    if (hdr_valid) begin
      if (hq.size() == 0) chk("hdr_unexpected", 112'(1), 112'(0));
      else begin
        chk("hdr_fields", {dest, src, etype}, hq[0]);
        if (hdr_ready) begin
          last_hdr = hq.pop_front();
          hdr_cnt++;
        end
      end
    end
    if (pl_valid && pl_ready) begin
      if (pq.size() == 0) chk("pl_unexpected", 112'(1), 112'(0));
      else begin
        chk("pl_byte", 112'({pl_data, pl_last, pl_user}), 112'(pq[0]));
        last_pl = pq.pop_front();
        pl_cnt++;
      end
    end
    if (err) begin
      err_seen++;
      if (err_prev) chk("err_one_cycle", 112'(err_prev), 112'(0));
    end
    err_prev = err;
    if (s_tvalid && s_tready && drv_idx == 0) chk("b0_while_hdr_valid", 112'(hdr_valid), 112'(0));
  end

  task automatic wait_acc();
    logic acc;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      if (acc) break;
      if (c > 2000) begin
        $display("FAIL accept_timeout: byte %0d not accepted", drv_idx);
        $fatal(1);
      end
    end
  endtask

  task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int len, input logic user, input int abort_at);
    logic [111:0] h;
    int stop;
    h = {d, s, t};
    stop = abort_at >= 0 ? 14 + abort_at : len;
    if (len <= 14) exp_err++;
    else begin
      hq.push_back(h);
      for (int i = 14; i < stop; i++)
        pq.push_back({pbyte(i, len), i == len - 1, user && i == len - 1});
    end
    for (int i = 0; i < len; i++) begin
      if (i == stop) begin
        reset = 1'b1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        drv_idx = -1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_hdr_valid", 112'(hdr_valid), 112'(0));
        chk("rst_pl_valid", 112'({pl_valid, pl_data, pl_last, pl_user}), 112'(0));
        chk("rst_busy_err", 112'({busy, err, s_tready}), 112'(0));
        chk("rst_fields", {dest, src, etype}, 112'(0));
        chk("rst_queues", 112'(hq.size() + pq.size()), 112'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        return;
      end
      drv_idx = i;
      s_tdata = i < 14 ? h[111 - 8 * i -: 8] : pbyte(i, len);
      s_tvalid = 1'b1;
      s_tlast = i == len - 1;
      s_tuser = user;
      wait_acc();
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
    drv_idx = -1;
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tready", 112'(s_tready), 112'(0));
    chk("reset_outs", 112'({hdr_valid, pl_valid, busy, err}), 112'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    // V1 basic frame
    send_frame(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0806, 60, 1'b0, -1);
    repeat (5) @(posedge clk);
    #1;
    chk("v1_dest", 112'(last_hdr[111:64]), 112'(48'hFFFFFFFFFFFF));
    chk("v1_src", 112'(last_hdr[63:16]), 112'(48'h020000000001));
    chk("v1_type", 112'(last_hdr[15:0]), 112'(16'h0806));
    chk("v1_pl_count", 112'(pl_cnt), 112'(46));
    chk("v1_last_tlast_tuser", 112'(last_pl[1:0]), 112'(2'b10));
    chk("v1_idle", 112'({busy, hdr_valid}), 112'(0));
    // V3 early termination then a good frame
    send_frame(48'h112233445566, 48'hA0A1A2A3A4A5, 16'h0800, 8, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1 chk("v3_err_count", 112'(err_seen), 112'(1));
    send_frame(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h86DD, 20, 1'b0, -1);
    repeat (5) @(posedge clk);
    #1 chk("v3_hdr_count", 112'(hdr_cnt), 112'(2));
`ifdef ETH_HDR_PARSER_STATS_EN
    chk("v6_stat_frames", 112'(stat_frames), 112'(2));
    chk("v6_stat_early", 112'(stat_early_term), 112'(1));
`endif
    // V2 header backpressure across back-to-back frames
    hdr_ready = 1'b0;
    fork
      begin
        send_frame(48'h010203040506, 48'h0708090A0B0C, 16'h1234, 20, 1'b0, -1);
        send_frame(48'hCAFEBABE0001, 48'hDEADBEEF0002, 16'h5678, 20, 1'b0, -1);
      end
      begin
        for (int c = 0; c < 500 && !hdr_valid; c++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1 hdr_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1 chk("v2_hdr_count", 112'(hdr_cnt), 112'(4));
    // V4 payload backpressure with tuser on the last byte
    base = pl_cnt;
    pl_toggle = 1'b1;
    send_frame(48'h00AABBCCDDEE, 48'h001122334455, 16'h88B5, 64, 1'b1, -1);
    repeat (6) @(posedge clk);
    pl_toggle = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("v4_pl_count", 112'(pl_cnt - base), 112'(50));
    chk("v4_last_tuser", 112'(last_pl[1:0]), 112'(2'b11));
    // V5 reset at payload byte 10, then a fresh frame
    base = err_seen;
    send_frame(48'h665544332211, 48'h0F0E0D0C0B0A, 16'h0842, 40, 1'b0, 10);
    send_frame(48'h123456789ABC, 48'hFEDCBA987654, 16'h9000, 20, 1'b0, -1);
    repeat (30) @(posedge clk);
    #1;
    chk("v5_no_err", 112'(err_seen - base), 112'(0));
    chk("end_queues_empty", 112'(hq.size() + pq.size()), 112'(0));
    chk("end_err_count", 112'(err_seen), 112'(exp_err));
    chk("end_hdr_count", 112'(hdr_cnt), 112'(7));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
